// File: rtl/b13_serial_rx.sv
// ---------------------------------------------------------------------------
// b13_serial_rx
//   Serial receiver for the b13 transmitter's data_out line. Recovers 10-bit
//   frames (start 0, eight data bits MSB first, stop 1) at a fixed bit period
//   and presents each byte with a valid/ack handshake.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   rx_in      in   serial line, idle high, asynchronous to clock
//   rx_ack     in   consumer accepts the byte in rx_data
//   rx_data    out  [7:0] last good byte
//   rx_valid   out  rx_data holds an unacknowledged byte
//   dsr        out  ready for another byte (~rx_valid), to transmitter dsr
//   frame_err  out  one-cycle pulse when a stop bit samples as 0
//   overrun    out  sticky: an unacknowledged byte was overwritten
//   busy       out  receiver is inside a frame (any state but R_IDLE)
// ---------------------------------------------------------------------------
module b13_serial_rx #(
    parameter int BIT_PERIOD  = 106,
    parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       dsr,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_START = 2'b01,
        R_DATA  = 2'b10,
        R_STOP  = 2'b11
    } state_t;

    localparam logic [9:0] LP_HALF_LAST = 10'(HALF_PERIOD - 1);
    localparam logic [9:0] LP_BIT_LAST  = 10'(BIT_PERIOD - 1);

    logic       r_sync;
    logic       r_rx_s;
    logic       r_rx_s_d;
    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_cnt;
    logic [2:0] r_bidx;
    logic [7:0] r_sh;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_frame_err;
    logic       r_overrun;
    logic       r_busy;

    logic w_fall;
    logic w_start_tick;
    logic w_data_tick;
    logic w_stop_tick;
    logic w_good_stop;
    logic w_bad_stop;
    logic w_ack;
    logic w_cnt_clear;

    // Falling edge needs the previous sample high, so a line left low after a
    // framing error cannot retrigger until it has gone back to idle.
    assign w_fall       = !r_rx_s && r_rx_s_d;
    assign w_start_tick = (r_state == R_START) && (r_cnt == LP_HALF_LAST);
    assign w_data_tick  = (r_state == R_DATA)  && (r_cnt == LP_BIT_LAST);
    assign w_stop_tick  = (r_state == R_STOP)  && (r_cnt == LP_BIT_LAST);
    assign w_good_stop  = w_stop_tick &&  r_rx_s;
    assign w_bad_stop   = w_stop_tick && !r_rx_s;
    assign w_ack        = rx_ack && r_rx_valid;

    // Counter restarts on every state entry and after each data bit; it is
    // parked at zero while idle.
    assign w_cnt_clear  = (w_state_next != r_state) || w_data_tick || (r_state == R_IDLE);

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: synchroniser flops reset to the idle line level so reset
            // release can never look like a start edge.
            r_sync   <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop in the chain samples its pre-edge input.
            r_sync   <= rx_in;
            r_rx_s   <= r_sync;
            r_rx_s_d <= r_rx_s;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: next state defaults to the current state before the case so
        // no path leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            R_IDLE:  if (w_fall)       w_state_next = R_START;
            R_START: if (w_start_tick) w_state_next = r_rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (w_data_tick && (r_bidx == 3'd7)) w_state_next = R_STOP;
            R_STOP:  if (w_stop_tick)  w_state_next = R_IDLE;
            default:                   w_state_next = R_IDLE;
        endcase
    end

    // Bit timing and data path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_bidx <= '0;
            r_sh   <= '0;
        end else begin
            r_cnt <= w_cnt_clear ? 10'd0 : r_cnt + 10'd1;
            if (w_start_tick) begin
                r_bidx <= 3'd0;
            end else if (w_data_tick && (r_bidx != 3'd7)) begin
                r_bidx <= r_bidx + 3'd1;
            end
            // MSB arrives first, so shifting left leaves it in bit 7.
            if (w_data_tick) begin
                r_sh <= {r_sh[6:0], r_rx_s};
            end
        end
    end

    // Handshake and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_busy      <= (w_state_next != R_IDLE);
            if (w_good_stop) begin
                r_rx_data  <= r_sh;
                r_rx_valid <= 1'b1;
                // A same-cycle ack consumes the old byte, so nothing is lost.
                r_overrun  <= r_rx_valid && !rx_ack;
            end else if (w_ack) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign dsr       = ~r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_b13_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_b13_serial_rx
//   Self-checking bench for b13_serial_rx. Two receivers run side by side on
//   separate lines: index 0 uses the default bit period (106), index 1 uses a
//   bit period of 10. Frames are driven as serial bit streams; a negedge
//   monitor records every end-of-frame (busy falling) and every frame_err
//   pulse with its cycle number, and the expected byte, timing and flags
//   come from the frame-level rules: stop sample lands 2 sync clocks + 1 edge
//   detect clock + HALF + 9*BIT after the start bit is driven.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_b13_serial_rx;

    localparam int BP0 = 106;
    localparam int BP1 = 10;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        valid;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx_in     [2];
    logic       rx_ack    [2];
    logic [7:0] rx_data   [2];
    logic       rx_valid  [2];
    logic       dsr       [2];
    logic       frame_err [2];
    logic       overrun   [2];
    logic       busy      [2];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned busy_cnt [2] = '{0, 0};
    int unsigned fe_cnt   [2] = '{0, 0};
    int unsigned fe_cyc   [2] = '{0, 0};
    logic        prev_busy[2] = '{1'b0, 1'b0};
    ev_t         ev_q     [2][$];

    always #5 clock = ~clock;

    b13_serial_rx #(.BIT_PERIOD(BP0)) u_dut_slow (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_in    (rx_in[0]),
        .rx_ack   (rx_ack[0]),
        .rx_data  (rx_data[0]),
        .rx_valid (rx_valid[0]),
        .dsr      (dsr[0]),
        .frame_err(frame_err[0]),
        .overrun  (overrun[0]),
        .busy     (busy[0])
    );

    b13_serial_rx #(.BIT_PERIOD(BP1)) u_dut_fast (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_in    (rx_in[1]),
        .rx_ack   (rx_ack[1]),
        .rx_data  (rx_data[1]),
        .rx_valid (rx_valid[1]),
        .dsr      (dsr[1]),
        .frame_err(frame_err[1]),
        .overrun  (overrun[1]),
        .busy     (busy[1])
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        ev_t e;
        for (int k = 0; k < 2; k++) begin
            if (prev_busy[k] && !busy[k]) begin
                e.cyc   = cyc;
                e.data  = rx_data[k];
                e.valid = rx_valid[k];
                ev_q[k].push_back(e);
            end
            if (busy[k])      busy_cnt[k] <= busy_cnt[k] + 1;
            if (frame_err[k]) begin
                fe_cnt[k] <= fe_cnt[k] + 1;
                fe_cyc[k] <= cyc;
            end
            prev_busy[k] <= busy[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bp_of(input int k);
        return (k == 0) ? BP0 : BP1;
    endfunction

    // Start-bit drive to stop-sample edge, in clocks.
    function automatic int lat_of(input int k);
        int bp;
        bp = bp_of(k);
        return 3 + bp / 2 + 9 * bp;
    endfunction

    // Drives one full frame starting at the current negedge; returns on the
    // negedge after the stop bit period. The line is left at the stop level.
    task automatic send_frame(input int k, input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {1'b0, b, stop_bit};
        for (int i = 9; i >= 0; i--) begin
            rx_in[k] = bits[i];
            repeat (bp_of(k)) @(negedge clock);
        end
    endtask

    task automatic ack_pulse(input int k);
        rx_ack[k] = 1'b1;
        @(negedge clock);
        rx_ack[k] = 1'b0;
    endtask

    task automatic expect_event(input int k, input string tag, input logic [31:0] exp_cyc,
                                input logic [7:0] exp_data, input logic exp_valid);
        ev_t e;
        if (ev_q[k].size() == 0) begin
            check({tag, "_present"}, 32'(ev_q[k].size()), 32'd1);
        end else begin
            e = ev_q[k].pop_front();
            check({tag, "_cyc"},   e.cyc,          exp_cyc);
            check({tag, "_data"},  32'(e.data),    32'(exp_data));
            check({tag, "_valid"}, 32'(e.valid),   32'(exp_valid));
        end
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check({tag, "_data"},  32'(rx_data[k]),   32'h00);
        check({tag, "_valid"}, 32'(rx_valid[k]),  32'd0);
        check({tag, "_dsr"},   32'(dsr[k]),       32'd1);
        check({tag, "_ferr"},  32'(frame_err[k]), 32'd0);
        check({tag, "_ovr"},   32'(overrun[k]),   32'd0);
        check({tag, "_busy"},  32'(busy[k]),      32'd0);
    endtask

    // Two frames with no idle gap, each acknowledged after it lands.
    task automatic back_to_back(input int k, input string tag);
        int unsigned s, fe0, bp, lat;
        bp  = bp_of(k);
        lat = lat_of(k);
        fe0 = fe_cnt[k];
        s   = cyc;
        fork
            begin
                send_frame(k, 8'h00, 1'b1);
                send_frame(k, 8'hFF, 1'b1);
            end
            begin
                repeat (lat + 1) @(negedge clock);
                ack_pulse(k);
                repeat (10 * bp - 1) @(negedge clock);
                ack_pulse(k);
            end
        join
        check({tag, "_nev"}, 32'(ev_q[k].size()), 32'd2);
        expect_event(k, {tag, "_b0"}, s + lat,          8'h00, 1'b1);
        expect_event(k, {tag, "_b1"}, s + 10 * bp + lat, 8'hFF, 1'b1);
        check({tag, "_ferr"},  fe_cnt[k] - fe0,   32'd0);
        check({tag, "_ovr"},   32'(overrun[k]),   32'd0);
        check({tag, "_valid"}, 32'(rx_valid[k]),  32'd0);
    endtask

    // Random frames (occasionally with a bad stop bit) against a frame-level
    // model of valid / overrun / last good byte.
    task automatic random_frames(input int k, input int n, input string tag);
        logic [7:0]  m_data, b;
        logic        m_valid, m_ovr, stop_bit;
        int unsigned s, fe0, gap, lat;
        lat     = lat_of(k);
        m_data  = rx_data[k];
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        for (int it = 0; it < n; it++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            fe0      = fe_cnt[k];
            s        = cyc;
            send_frame(k, b, stop_bit);
            if (stop_bit) begin
                m_ovr   = m_valid;
                m_valid = 1'b1;
                m_data  = b;
                expect_event(k, {tag, "_frame"}, s + lat, m_data, m_valid);
                check({tag, "_ferr_none"}, fe_cnt[k] - fe0, 32'd0);
            end else begin
                rx_in[k] = 1'b1;
                expect_event(k, {tag, "_bad"}, s + lat, m_data, m_valid);
                check({tag, "_ferr_cnt"}, fe_cnt[k] - fe0, 32'd1);
                check({tag, "_ferr_cyc"}, fe_cyc[k],       s + lat);
            end
            check({tag, "_data"}, 32'(rx_data[k]), 32'(m_data));
            check({tag, "_ovr"},  32'(overrun[k]), 32'(m_ovr));
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse(k);
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            check({tag, "_valid"}, 32'(rx_valid[k]), 32'(m_valid));
            check({tag, "_dsr"},   32'(dsr[k]),      32'(!m_valid));
            gap = $urandom_range(stop_bit ? 0 : 2, 2 * bp_of(k));
            repeat (gap) @(negedge clock);
        end
    endtask

    initial begin
        int unsigned s, fe0, bz0, lat0;
        lat0      = lat_of(0);
        reset_n   = 1'b0;
        rx_in[0]  = 1'b1;
        rx_in[1]  = 1'b1;
        rx_ack[0] = 1'b0;
        rx_ack[1] = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals(0, "rst0");
        check_reset_vals(1, "rst1");
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        ev_q[0].delete();
        ev_q[1].delete();

        // Nominal byte 0xA5, then a one-cycle ack, then an ack with nothing
        // pending.
        s = cyc;
        send_frame(0, 8'hA5, 1'b1);
        expect_event(0, "nom", s + lat0, 8'hA5, 1'b1);
        check("nom_dsr", 32'(dsr[0]), 32'd0);
        ack_pulse(0);
        check("nom_ack_valid", 32'(rx_valid[0]), 32'd0);
        check("nom_ack_dsr",   32'(dsr[0]),      32'd1);
        ack_pulse(0);
        check("idle_ack_valid", 32'(rx_valid[0]), 32'd0);
        check("idle_ack_data",  32'(rx_data[0]),  32'hA5);

        // False start: 20 clocks low, then high.
        bz0 = busy_cnt[0];
        fe0 = fe_cnt[0];
        s   = cyc;
        rx_in[0] = 1'b0;
        repeat (20) @(negedge clock);
        rx_in[0] = 1'b1;
        repeat (150) @(negedge clock);
        expect_event(0, "fstart", s + 3 + BP0 / 2, 8'hA5, 1'b0);
        check("fstart_busy_cycles", busy_cnt[0] - bz0, 32'(BP0 / 2));
        check("fstart_ferr",        fe_cnt[0] - fe0,   32'd0);
        check("fstart_valid",       32'(rx_valid[0]),  32'd0);

        // Framing error on 0x3C, line then held low for 300 more clocks.
        fe0 = fe_cnt[0];
        s   = cyc;
        send_frame(0, 8'h3C, 1'b0);
        bz0 = busy_cnt[0];
        repeat (300) @(negedge clock);
        expect_event(0, "ferr", s + lat0, 8'hA5, 1'b0);
        check("ferr_cnt",     fe_cnt[0] - fe0,   32'd1);
        check("ferr_cyc",     fe_cyc[0],         s + lat0);
        check("ferr_valid",   32'(rx_valid[0]),  32'd0);
        check("ferr_low_idle", busy_cnt[0] - bz0, 32'd0);
        rx_in[0] = 1'b1;
        repeat (20) @(negedge clock);
        check("ferr_high_idle", busy_cnt[0] - bz0, 32'd0);

        // Overrun, then a good stop with a same-cycle ack clears it.
        s = cyc;
        send_frame(0, 8'h11, 1'b1);
        expect_event(0, "ovr_b1", s + lat0, 8'h11, 1'b1);
        check("ovr_b1_flag", 32'(overrun[0]), 32'd0);
        s = cyc;
        send_frame(0, 8'h22, 1'b1);
        expect_event(0, "ovr_b2", s + lat0, 8'h22, 1'b1);
        check("ovr_b2_flag", 32'(overrun[0]), 32'd1);
        s = cyc;
        fork
            send_frame(0, 8'h33, 1'b1);
            begin
                repeat (lat0 - 1) @(negedge clock);
                ack_pulse(0);
            end
        join
        expect_event(0, "ovr_b3", s + lat0, 8'h33, 1'b1);
        check("ovr_b3_flag",  32'(overrun[0]),  32'd0);
        check("ovr_b3_valid", 32'(rx_valid[0]), 32'd1);
        ack_pulse(0);
        check("ovr_ack_valid", 32'(rx_valid[0]), 32'd0);

        // Reset during data bit 4 of 0xFF, then a clean 0x80.
        fork
            send_frame(0, 8'hFF, 1'b1);
            begin
                repeat (3 + BP0 / 2 + 4 * BP0 + 50) @(negedge clock);
                check("midrst_busy_before", 32'(busy[0]), 32'd1);
                reset_n = 1'b0;
                #1;
                check_reset_vals(0, "midrst");
                repeat (3) @(negedge clock);
                reset_n = 1'b1;
            end
        join
        ev_q[0].delete();
        ev_q[1].delete();
        check("midrst_idle_after", 32'(busy[0]), 32'd0);
        s = cyc;
        send_frame(0, 8'h80, 1'b1);
        expect_event(0, "post_rst", s + lat0, 8'h80, 1'b1);
        ack_pulse(0);

        back_to_back(0, "b2b_slow");
        back_to_back(1, "b2b_fast");

        random_frames(0, 4,  "rnd_slow");
        random_frames(1, 30, "rnd_fast");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
